piso_bit_serializer: RTL and testbench
======================================

# piso_bit_serializer

Parallel-in/serial-out stage that feeds the single-bit `in` input of the Moore sequence detectors. Accepts a WIDTH-bit word over a valid/ready handshake and emits it MSB-first, one bit per clock, with a per-bit valid flag and a last-bit marker. Consecutive words stream with no idle bit between them, so patterns spanning word boundaries reach the detector intact for overlapping detection.

## Interface
- `WIDTH`, 8, word width in bits; legal range 2 to 32.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `in_data`  input  WIDTH  parallel word; sampled only on an accepting edge.
- `in_valid`  input  1  upstream has a word.
- `in_ready`  output  1  block can take a word this cycle.
- `out_bit`  output  1  serial bit; connects to detector `in`.
- `out_valid`  output  1  `out_bit` carries a payload or parity bit this cycle.
- `out_last`  output  1  final bit of the current word.

## Operation
- States:
  - IDLE: no word loaded.
  - SHIFT: emitting data bits.
  - PARITY: emitting the parity bit; exists only with `SER_PARITY_EN`.
- Accept: an edge where `in_valid && in_ready`. It loads `in_data` into the shift register, sets the bit counter to WIDTH-1 and enters SHIFT.
- `in_ready` is combinational from state only. It is 1 in:
  - IDLE;
  - SHIFT with counter==0 when parity is disabled;
  - PARITY.
- `in_ready` is 0 in every other state and while `rst` is high. It never depends on `in_valid`.
- SHIFT behaviour:
  - `out_bit` = shift register MSB; `out_valid` = 1.
  - Each edge shifts left by one and decrements the counter.
  - At counter==0, `out_last` = 1 when parity is disabled.
- End of word:
  - Parity disabled: at counter==0, move to SHIFT with a fresh word if one is accepted on that edge, otherwise to IDLE.
  - Parity enabled: at counter==0, move to PARITY.
  - From PARITY: move to SHIFT with a fresh word if one is accepted on that edge, otherwise to IDLE.
- IDLE outputs: `out_bit`=0, `out_valid`=0, `out_last`=0.
- While not ready, `in_data` and `in_valid` are ignored. A held `in_valid` is not lost; it is accepted at the next ready edge.
- Counter width is $clog2(WIDTH). It never wraps below 0; the state change happens first.

## Timing
- Reset: while `rst` is high, and immediately on its assertion:
  - state = IDLE; shift register, counter and parity register = 0;
  - `out_bit`, `out_valid`, `out_last` and `in_ready` = 0.
- First ready: the first cycle after `rst` deasserts.
- Latency: a word accepted at edge k drives its MSB during the cycle after edge k. Bit i (MSB=0) is driven during cycle k+1+i.
- Throughput:
  - Without parity: one word per WIDTH cycles.
  - With parity: one word per WIDTH+1 cycles.
  - No bubble between words when `in_valid` is held high.
- Reset mid-word: the remaining bits are discarded. No partial word resumes after release.
- `out_bit`, `out_valid` and `out_last` are decoded from registered state and the shift register only, so they are glitch-free for the detector.

## Configuration
- Macro: `SER_PARITY_EN`.
- Defined:
  - One even-parity bit is appended after the LSB. Parity = XOR of the loaded word, captured at accept.
  - `out_valid`=1 and `out_last`=1 during the parity bit; `out_last` is 0 on the LSB.
- Undefined:
  - The PARITY state and the parity register are absent.
  - `out_last` is asserted on the LSB; words are exactly WIDTH bits.

## Structure
- Shared package `serializer_pkg`:
  - state enum typedef (IDLE, SHIFT, PARITY);
  - WIDTH range limits as localparams.
- Sub-module `even_parity_calc`: a WIDTH-parameterised XOR reduction, instantiated only under `SER_PARITY_EN`.
- Everything else is flat in one always block for state/counter/shift register plus output decode.

## Test plan
- **Single word.** WIDTH=8, reset released, then one word 8'hB6. Expect `out_bit` = 1,0,1,1,0,1,1,0 on 8 consecutive cycles with `out_valid`=1. `out_last` is 1 only on the 8th bit. IDLE follows with all outputs 0.
- **Back-to-back words.** 8'hB0 then 8'h0B with `in_valid` held high. Expect 16 contiguous valid bits with `in_ready` pulsing only on bit 8. A downstream overlapping 1011 detector fires twice.
- **Parity.** `SER_PARITY_EN` defined, word 8'hB6 (five ones). Expect 9 valid bits: data then parity=1. `out_last` is on the 9th bit only, and `in_ready` is 1 only in that cycle.
- **Reset mid-word.** Assert `rst` after 3 bits of 8'hFF. Expect `out_valid`=0 and `in_ready`=0 immediately. After release: `in_ready`=1, `out_valid`=0, no residual bits.
- **Stall.** Present 8'hAA while busy, changing `in_data` to 8'h55 before ready. Expect 8'h55 to be the word accepted at the ready edge, with no corruption of the word in flight.
- **Minimum width.** WIDTH=4, word 4'hB. Expect 1,0,1,1 with `out_last` on the 4th bit.

Source files
------------

// File: rtl/serializer_pkg.sv
// Shared types and limits for the PISO bit serializer.
// Holds the serializer state encoding and the legal WIDTH range.
package serializer_pkg;

    localparam int SER_WIDTH_MIN = 2;
    localparam int SER_WIDTH_MAX = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } ser_state_t;

endpackage

// File: rtl/even_parity_calc.sv
// Even-parity generator for the serializer's optional parity bit.
// Only built when SER_PARITY_EN is defined; the default build has no parity
// path, so this module does not exist there.
`ifdef SER_PARITY_EN
module even_parity_calc #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    output logic             parity
);

    // Parity bit that makes the total count of ones even.
    always_comb begin
        parity = ^data;
    end

endmodule
`endif

// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out stage feeding a single-bit sequence detector input.
// Words are taken over valid/ready and shifted out MSB-first, one bit per
// clock, with no idle bit between consecutive words.
// Optional macro SER_PARITY_EN appends one even-parity bit after the LSB.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no word loaded, outputs quiet, ready for a word
// SHIFT  | emitting data bits, MSB of shift register on out_bit
// PARITY | emitting the captured parity bit (SER_PARITY_EN only)
module piso_bit_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_bit,
    output logic             out_valid,
    output logic             out_last
);

    localparam int              CNT_W   = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Catch an out-of-range WIDTH at elaboration rather than in silicon.
    if (WIDTH < SER_WIDTH_MIN || WIDTH > SER_WIDTH_MAX) begin : g_width_check
        $error("piso_bit_serializer: WIDTH out of range");
    end

    ser_state_t       state, state_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             accept;

`ifdef SER_PARITY_EN
    logic par, par_nxt, word_par;

    even_parity_calc #(
        .WIDTH (WIDTH)
    ) u_even_parity_calc (
        .data   (in_data),
        .parity (word_par)
    );
`endif

    // Registered state, bit counter, shift register (and parity bit).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
`ifdef SER_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            sreg  <= sreg_nxt;
            cnt   <= cnt_nxt;
`ifdef SER_PARITY_EN
            par   <= par_nxt;
`endif
        end
    end

    // Ready depends on registered state only, never on in_valid, and is held
    // low during reset so nothing can be accepted while the block is cleared.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:    in_ready = 1'b1;
`ifdef SER_PARITY_EN
                PARITY:  in_ready = 1'b1;
`else
                SHIFT:   in_ready = (cnt == '0);
`endif
                default: in_ready = 1'b0;
            endcase
        end
        accept = in_valid && in_ready;
    end

    // Next-state: load on accept, shift while bits remain, and chain straight
    // into the next word at end of word so the stream has no bubble.
    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        cnt_nxt   = cnt;
`ifdef SER_PARITY_EN
        par_nxt   = par;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                    sreg_nxt  = in_data;
                    cnt_nxt   = CNT_TOP;
`ifdef SER_PARITY_EN
                    par_nxt   = word_par;
`endif
                end
            end
            SHIFT: begin
                if (cnt != '0) begin
                    sreg_nxt = {sreg[WIDTH-2:0], 1'b0};
                    cnt_nxt  = cnt - CNT_ONE;
                end else begin
`ifdef SER_PARITY_EN
                    state_nxt = PARITY;
                    sreg_nxt  = '0;
`else
                    if (accept) begin
                        state_nxt = SHIFT;
                        sreg_nxt  = in_data;
                        cnt_nxt   = CNT_TOP;
                    end else begin
                        state_nxt = IDLE;
                        sreg_nxt  = '0;
                    end
`endif
                end
            end
`ifdef SER_PARITY_EN
            PARITY: begin
                if (accept) begin
                    state_nxt = SHIFT;
                    sreg_nxt  = in_data;
                    cnt_nxt   = CNT_TOP;
                    par_nxt   = word_par;
                end else begin
                    state_nxt = IDLE;
                    sreg_nxt  = '0;
                    cnt_nxt   = '0;
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
                sreg_nxt  = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Serial outputs decoded from registered state only, so the detector sees
    // no combinational glitches from the upstream handshake.
    always_comb begin
        out_bit   = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (state)
            SHIFT: begin
                out_bit   = sreg[WIDTH-1];
                out_valid = 1'b1;
`ifndef SER_PARITY_EN
                out_last  = (cnt == '0);
`endif
            end
`ifdef SER_PARITY_EN
            PARITY: begin
                out_bit   = par;
                out_valid = 1'b1;
                out_last  = 1'b1;
            end
`endif
            default: begin
                out_bit   = 1'b0;
                out_valid = 1'b0;
                out_last  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Self-checking bench for piso_bit_serializer: WIDTH=8 and WIDTH=4 instances,
// expected serial bits queued at accept and compared as they appear.
module tb_piso_bit_serializer;

`ifdef SER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] d8  = '0;
    logic       v8  = 1'b0;
    logic       rdy8, ob8, ov8, ol8;
    logic [3:0] d4  = '0;
    logic       v4  = 1'b0;
    logic       rdy4, ob4, ov4, ol4;

    always #5 clk = ~clk;

    piso_bit_serializer #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (d8),
        .in_valid  (v8),
        .in_ready  (rdy8),
        .out_bit   (ob8),
        .out_valid (ov8),
        .out_last  (ol8)
    );

    piso_bit_serializer #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (d4),
        .in_valid  (v4),
        .in_ready  (rdy4),
        .out_bit   (ob4),
        .out_valid (ov4),
        .out_last  (ol4)
    );

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    typedef struct {
        logic [7:0] w;
        logic       p;
    } vec_t;

    exp_t       q8[$];
    exp_t       q4[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         det_cnt = 0;
    logic [3:0] hist    = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_word(input int which, input logic [31:0] w,
                                      input int width, input logic p);
        exp_t e;
        for (int i = width - 1; i >= 0; i--) begin
            e.b    = w[i];
            e.last = (i == 0) && (PAR == 0);
            if (which == 8) q8.push_back(e);
            else            q4.push_back(e);
        end
        if (PAR != 0) begin
            e.b    = p;
            e.last = 1'b1;
            if (which == 8) q8.push_back(e);
            else            q4.push_back(e);
        end
    endfunction

    // Scoreboard for the 8-bit instance plus an overlapping 1011 detector model.
    always @(negedge clk) begin
        exp_t e;
        if (ov8) begin
            if (q8.size() == 0) begin
                check("dut8 unexpected valid", ov8, 1'b0);
            end else begin
                e = q8.pop_front();
                check("dut8 out_bit", ob8, e.b);
                check("dut8 out_last", ol8, e.last);
            end
            hist = {hist[2:0], ob8};
            if (hist == 4'b1011) det_cnt++;
        end else begin
            hist = '0;
            check("dut8 idle bit/last", {ob8, ol8}, 2'b00);
        end
    end

    // Scoreboard for the 4-bit instance.
    always @(negedge clk) begin
        exp_t e;
        if (ov4) begin
            if (q4.size() == 0) begin
                check("dut4 unexpected valid", ov4, 1'b0);
            end else begin
                e = q4.pop_front();
                check("dut4 out_bit", ob4, e.b);
                check("dut4 out_last", ol4, e.last);
            end
        end else begin
            check("dut4 idle bit/last", {ob4, ol4}, 2'b00);
        end
    end

    task automatic send(input int which, input logic [31:0] w, input logic p, input int width);
        int   t;
        logic r;
        t = 0;
        if (which == 8) begin d8 = w[7:0]; v8 = 1'b1; end
        else            begin d4 = w[3:0]; v4 = 1'b1; end
        while (1) begin
            r = (which == 8) ? rdy8 : rdy4;
            if (r === 1'b1 || t >= 100) break;
            @(posedge clk); #1;
            t++;
        end
        if (t >= 100) check("send ready timeout", r, 1'b1);
        push_word(which, w, width, p);
        @(posedge clk); #1;
        if (which == 8) v8 = 1'b0;
        else            v4 = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q8.size() != 0 || q4.size() != 0) && t < 300) begin
            @(posedge clk);
            t++;
        end
        check("drain pending bits", q8.size() + q4.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int   nb;
        int   t;
        vecs[0] = '{8'hB6, 1'b1};
        vecs[1] = '{8'h00, 1'b0};
        vecs[2] = '{8'hFF, 1'b0};
        vecs[3] = '{8'h01, 1'b1};
        vecs[4] = '{8'h80, 1'b1};
        vecs[5] = '{8'h5A, 1'b0};
        vecs[6] = '{8'hC3, 1'b0};
        vecs[7] = '{8'h7E, 1'b0};
        nb = 8 + PAR;

        // reset state
        #1;
        check("reset in_ready", rdy8, 1'b0);
        check("reset out_valid", ov8, 1'b0);
        check("reset dut4 in_ready", rdy4, 1'b0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        check("first ready after reset", rdy8, 1'b1);
        check("idle out_valid after reset", ov8, 1'b0);
        @(posedge clk); #1;

        // single word with first-bit latency
        send(8, 32'hB6, 1'b1, 8);
        @(negedge clk);
        check("first bit latency valid", ov8, 1'b1);
        drain();
        check("idle ready after word", rdy8, 1'b1);
        check("idle out_valid after word", ov8, 1'b0);

        // table of words
        for (int i = 0; i < 8; i++) send(8, {24'h0, vecs[i].w}, vecs[i].p, 8);
        drain();

        // back-to-back with ready pulse, contiguity and detector
        det_cnt = 0;
        d8 = 8'hB0; v8 = 1'b1;
        push_word(8, 32'hB0, 8, 1'b1);
        @(posedge clk); #1;
        d8 = 8'h0B;
        for (int i = 0; i < nb; i++) begin
            check("b2b in_ready pulse", rdy8, (i == nb - 1));
            if (i == nb - 1) push_word(8, 32'h0B, 8, 1'b1);
            @(negedge clk);
            check("b2b contiguous valid word1", ov8, 1'b1);
            @(posedge clk); #1;
        end
        v8 = 1'b0;
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            check("b2b contiguous valid word2", ov8, 1'b1);
            @(posedge clk); #1;
        end
        drain();
        check("overlapping 1011 detections", det_cnt, 2);

        // stall: data changes while busy, only the value at the ready edge counts
        send(8, 32'hC3, 1'b0, 8);
        d8 = 8'hAA; v8 = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        d8 = 8'h55;
        t = 0;
        while (rdy8 !== 1'b1 && t < 100) begin @(posedge clk); #1; t++; end
        check("stall ready reached", rdy8, 1'b1);
        push_word(8, 32'h55, 8, 1'b0);
        @(posedge clk); #1;
        v8 = 1'b0;
        drain();

        // reset mid-word
        send(8, 32'hFF, 1'b0, 8);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid-word reset out_valid", ov8, 1'b0);
        check("mid-word reset in_ready", rdy8, 1'b0);
        q8.delete();
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        check("post-reset in_ready", rdy8, 1'b1);
        check("post-reset out_valid", ov8, 1'b0);
        repeat (12) @(posedge clk);
        #1;
        check("no residual bits", ov8, 1'b0);

        // minimum-width instance
        send(4, 32'hB, 1'b1, 4);
        send(4, 32'h6, 1'b0, 4);
        drain();
        check("dut4 idle ready", rdy4, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
